onehot_strobe_decoder: RTL and testbench

Registered binary-to-one-hot decoder that turns an accepted select code into a one-hot strobe held for a programmable number of cycles, followed by a programmable idle gap. It is the decode-side counterpart of the team's 4-to-2 priority encoder: the encoder compresses a one-hot request into a code, and this block expands a code back into a timed one-hot select line. Upstream logic hands it codes through a valid/ready handshake; downstream consumers see a clean, glitch-free, registered one-hot output.

---
 rtl/onehot_strobe_decoder_if.sv | 25 ++
 rtl/onehot_strobe_decoder.sv | 105 ++++++++++
 tb/tb_onehot_strobe_decoder.sv | 138 +++++++++++++
 3 files changed

// File: rtl/onehot_strobe_decoder_if.sv
// Handshake and strobe bundle between an upstream code source and the one-hot strobe decoder.
// The source drives the code and enable; the decoder returns ready, strobe and status.
interface onehot_strobe_decoder_if #(
   parameter int SEL_W = 2
);
   localparam int OUT_W = 2 ** SEL_W;

   logic             en;
   logic             in_valid;
   logic [SEL_W-1:0] in_sel;
   logic             in_ready;
   logic [OUT_W-1:0] y;
   logic             busy;
   logic             done;

   modport master (
      output en, in_valid, in_sel,
      input  in_ready, y, busy, done
   );

   modport slave (
      input  en, in_valid, in_sel,
      output in_ready, y, busy, done
   );
endinterface

// File: rtl/onehot_strobe_decoder.sv
// Registered binary-to-one-hot decoder: an accepted code becomes a one-hot strobe held
// PULSE_LEN cycles, then one mandatory zero cycle plus GAP_LEN idle cycles before the next accept.
module onehot_strobe_decoder #(
   parameter int SEL_W     = 2,
   parameter int PULSE_LEN = 4,
   parameter int GAP_LEN   = 1
) (
   input logic                   clk,
   input logic                   rst_n,
   onehot_strobe_decoder_if.slave bus
);
   localparam int OUT_W   = 2 ** SEL_W;
   localparam int CNT_MAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
   localparam int CNT_W   = ($clog2(CNT_MAX + 1) > 1) ? $clog2(CNT_MAX + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACTIVE,
      S_GAP
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [SEL_W-1:0] sel_q;
   logic [OUT_W-1:0] y_q;
   logic             busy_q;
   logic             done_q;

   function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] s);
      logic [OUT_W-1:0] oh;
      oh = '0;
      for (int i = 0; i < OUT_W; i++) begin
         if (s == SEL_W'(i)) oh[i] = 1'b1;
      end
      return oh;
   endfunction

   assign bus.in_ready = (state == S_IDLE) && bus.en;
   assign bus.y        = y_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         cnt    <= '0;
         sel_q  <= '0;
         y_q    <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (!bus.en) begin
            // Abort: drop straight to IDLE without a done pulse.
            state  <= S_IDLE;
            cnt    <= '0;
            y_q    <= '0;
            busy_q <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (bus.in_valid) begin
                     sel_q  <= bus.in_sel;
                     y_q    <= decode(bus.in_sel);
                     busy_q <= 1'b1;
                     cnt    <= CNT_W'(PULSE_LEN - 1);
                     state  <= S_ACTIVE;
                  end
               end
               S_ACTIVE: begin
                  if (cnt == '0) begin
                     y_q    <= '0;
                     done_q <= 1'b1;
                     if (GAP_LEN > 0) begin
                        state  <= S_GAP;
                        cnt    <= CNT_W'(GAP_LEN - 1);
                        busy_q <= 1'b1;
                     end else begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                     end
                  end else begin
                     cnt <= cnt - 1'b1;
                     y_q <= decode(sel_q);
                  end
               end
               S_GAP: begin
                  if (cnt == '0) begin
                     state  <= S_IDLE;
                     busy_q <= 1'b0;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               default: begin
                  state  <= S_IDLE;
                  cnt    <= '0;
                  y_q    <= '0;
                  busy_q <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_onehot_strobe_decoder.sv
// Directed bench: per-cycle vector table on a GAP_LEN=1 instance, plus scripted
// back-to-back (GAP_LEN=0) and asynchronous-reset sequences.
module tb_onehot_strobe_decoder;
   logic clk;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   onehot_strobe_decoder_if #(.SEL_W(2)) b1 ();
   onehot_strobe_decoder_if #(.SEL_W(2)) b0 ();

   onehot_strobe_decoder #(.SEL_W(2), .PULSE_LEN(4), .GAP_LEN(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(b1)
   );
   onehot_strobe_decoder #(.SEL_W(2), .PULSE_LEN(4), .GAP_LEN(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(b0)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic       en;
      logic       vld;
      logic [1:0] sel;
      logic       rdy;
      logic [3:0] y;
      logic       busy;
      logic       done;
   } vec_t;

   vec_t tbl[14];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   initial begin
      int dones;
      logic [3:0] ey;

      // {en, vld, sel, ready-before-edge, y/busy/done after edge}
      tbl[0]  = '{1'b1, 1'b1, 2'd2, 1'b1, 4'b0100, 1'b1, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 2'd0, 1'b0, 4'b0100, 1'b1, 1'b0};
      tbl[2]  = '{1'b1, 1'b1, 2'd1, 1'b0, 4'b0100, 1'b1, 1'b0};
      tbl[3]  = '{1'b1, 1'b0, 2'd0, 1'b0, 4'b0100, 1'b1, 1'b0};
      tbl[4]  = '{1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 1'b1};
      tbl[5]  = '{1'b1, 1'b1, 2'd3, 1'b0, 4'b0000, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0, 1'b0};
      tbl[7]  = '{1'b0, 1'b1, 2'd1, 1'b0, 4'b0000, 1'b0, 1'b0};
      tbl[8]  = '{1'b0, 1'b1, 2'd1, 1'b0, 4'b0000, 1'b0, 1'b0};
      tbl[9]  = '{1'b1, 1'b1, 2'd3, 1'b1, 4'b1000, 1'b1, 1'b0};
      tbl[10] = '{1'b1, 1'b0, 2'd0, 1'b0, 4'b1000, 1'b1, 1'b0};
      tbl[11] = '{1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0};
      tbl[12] = '{1'b0, 1'b1, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0};
      tbl[13] = '{1'b1, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0, 1'b0};

      rst_n = 1'b0;
      b1.en = 1'b0; b1.in_valid = 1'b0; b1.in_sel = 2'd0;
      b0.en = 1'b0; b0.in_valid = 1'b0; b0.in_sel = 2'd0;

      #12;
      chk("rst_y",     32'(b1.y), 32'h0);
      chk("rst_busy",  32'(b1.busy), 32'h0);
      chk("rst_done",  32'(b1.done), 32'h0);
      chk("rst_rdy_en0", 32'(b1.in_ready), 32'h0);
      b1.en = 1'b1;
      #1 chk("rst_rdy_en1", 32'(b1.in_ready), 32'h1);
      @(negedge clk);
      rst_n = 1'b1;
      b0.en = 1'b1;

      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         b1.en = tbl[i].en; b1.in_valid = tbl[i].vld; b1.in_sel = tbl[i].sel;
         #1 chk($sformatf("v%0d_rdy", i), 32'(b1.in_ready), 32'(tbl[i].rdy));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_y", i),    32'(b1.y),    32'(tbl[i].y));
         chk($sformatf("v%0d_busy", i), 32'(b1.busy), 32'(tbl[i].busy));
         chk($sformatf("v%0d_done", i), 32'(b1.done), 32'(tbl[i].done));
      end
      @(negedge clk);
      b1.in_valid = 1'b0;

      // Back-to-back codes 0..3 with valid held: period of 5 (4 strobe + 1 zero/done cycle).
      dones = 0;
      for (int t = 0; t <= 20; t++) begin
         @(negedge clk);
         b0.in_valid = (t < 20);
         b0.in_sel   = 2'((t < 20) ? t / 5 : 0);
         @(posedge clk);
         #1;
         ey = 4'b0000;
         if (t < 20 && (t % 5) < 4) ey = 4'b0001 << (t / 5);
         chk($sformatf("b2b%0d_y", t),    32'(b0.y),    32'(ey));
         chk($sformatf("b2b%0d_done", t), 32'(b0.done), 32'((t % 5 == 4) ? 1 : 0));
         if (b0.done) dones++;
      end
      chk("b2b_done_count", 32'(dones), 32'd4);
      @(negedge clk);
      b0.in_valid = 1'b0;

      // Asynchronous reset between edges, mid-strobe.
      b1.in_valid = 1'b1; b1.in_sel = 2'd2;
      @(posedge clk);
      @(negedge clk);
      b1.in_valid = 1'b0;
      @(posedge clk);
      #3;
      chk("ar_pre_y", 32'(b1.y), 32'b0100);
      rst_n = 1'b0;
      #1;
      chk("ar_y",    32'(b1.y),    32'h0);
      chk("ar_busy", 32'(b1.busy), 32'h0);
      chk("ar_done", 32'(b1.done), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      b1.in_valid = 1'b1; b1.in_sel = 2'd1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         chk($sformatf("post%0d_y", c),    32'(b1.y),    32'((c < 4) ? 4'b0010 : 4'b0000));
         chk($sformatf("post%0d_done", c), 32'(b1.done), 32'((c == 4) ? 1 : 0));
         @(negedge clk);
         b1.in_valid = 1'b0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
